mul_div_unit: RTL and testbench

// Multi-cycle MIPS multiply/divide unit owning the HI/LO register pair (MULT, MULTU, DIV, DIVU, MTHI, MTLO).

---
 rtl/mul_div_unit.sv | 145 ++++++++++++++
 tb/tb_mul_div_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: fixed-latency multiply,
// restoring radix-2 divide, and MTHI/MTLO moves while idle.
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX} state_t;
  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic               uns;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [WIDTH-1:0]   quo, dvs, rem;
  logic               q_neg, r_neg, dz, ovf;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic               mul_last, iter_last, sgn;

  assign busy      = (state != IDLE);
  assign mul_last  = (cnt == CW'(MUL_LAT - 1));
  assign iter_last = (cnt == CW'(WIDTH - 1));
  assign sgn       = ~uns;

  // Product is taken from the latched operands, so a/b may change in flight.
  always_comb begin
    a_ext = uns ? {{WIDTH{1'b0}}, a_r} : {{WIDTH{a_r[WIDTH-1]}}, a_r};
    b_ext = uns ? {{WIDTH{1'b0}}, b_r} : {{WIDTH{b_r[WIDTH-1]}}, b_r};
    prod  = a_ext * b_ext;
  end

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nx  = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = op[1] ? DIV_PREP : MUL;
      MUL:      if (mul_last) state_nx = IDLE;
      DIV_PREP: state_nx = DIV_ITER;
      DIV_ITER: if (iter_last) state_nx = DIV_FIX;
      DIV_FIX:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      uns   <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      quo   <= '0;
      dvs   <= '0;
      rem   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            uns <= op[0];
            cnt <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            hi   <= prod[2*WIDTH-1:WIDTH];
            lo   <= prod[WIDTH-1:0];
            done <= 1'b1;
            cnt  <= '0;
          end
        end
        DIV_PREP: begin
          quo   <= (sgn && a_r[WIDTH-1]) ? -a_r : a_r;
          dvs   <= (sgn && b_r[WIDTH-1]) ? -b_r : b_r;
          q_neg <= sgn && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          r_neg <= sgn && a_r[WIDTH-1];
          dz    <= (b_r == '0);
          ovf   <= sgn && (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == '1);
          rem   <= '0;
          cnt   <= '0;
        end
        DIV_ITER: begin
          quo <= {quo[WIDTH-2:0], ge};
          rem <= rem_nx;
          cnt <= iter_last ? '0 : cnt + 1'b1;
        end
        DIV_FIX: begin
          done <= 1'b1;
          if (dz) begin
            lo <= '1;
            hi <= a_r;
          end else if (ovf) begin
            lo <= {1'b1, {(WIDTH-1){1'b0}}};
            hi <= '0;
          end else begin
            lo <= q_neg ? -quo : quo;
            hi <= r_neg ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corners plus randomized ops
// against an arithmetic reference model, with in-flight noise on start/moves.
module tb_mul_div_unit;
  localparam int W  = 32;
  localparam int ML = 4;

  logic         clk = 1'b0;
  logic         rst, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} as the architecture defines them.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int q, r;
    case (o)
      2'b00: begin p = longint'($signed(x)) * longint'($signed(y)); return p; end
      2'b01: return {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic noise, input string tag);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    logic        hold_ok;
    int          lat, n;
    exp = model(o, x, y);
    lat = o[1] ? W + 2 : ML;
    hi0 = hi;
    lo0 = lo;
    hold_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    mthi = noise; mtlo = noise; wdata = $urandom;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    chk({tag, "_done_low_start"}, 64'(done), 64'd0);
    if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (noise) begin
        start = 1'($urandom); mthi = 1'($urandom); mtlo = 1'($urandom);
        wdata = $urandom; op = 2'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (!done && (hi !== hi0 || lo !== lo0 || !busy)) hold_ok = 1'b0;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
  endtask

  initial begin
    logic [31:0] hi_s, lo_s;
    logic        seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(negedge clk); rst = 1'b0;

    do_op(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult_neg1x2");
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu_max_x2");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    do_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100_7");
    do_op(2'b11, 32'h1234, 32'd0, 1'b0, "divu_by0");
    do_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, "div_neg_by0");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
    // Start with moves asserted, then hammer start/moves while busy.
    do_op(2'b11, 32'd1000, 32'd3, 1'b1, "divu_noise");
    do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "mult_noise");

    @(negedge clk); mtlo = 1'b1; wdata = 32'h55; hi_s = hi;
    @(posedge clk); #1; mtlo = 1'b0;
    chk("mtlo_idle_lo", 64'(lo), 64'h55);
    chk("mtlo_idle_hi", 64'(hi), 64'(hi_s));
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", 64'(hi), 64'hA5A5_0F0F);
    chk("mthilo_lo", 64'(lo), 64'hA5A5_0F0F);

    // Reset in the middle of a divide.
    @(negedge clk); start = 1'b1; op = 2'b10; a = 32'd12345; b = 32'd17;
    @(posedge clk); #1; start = 1'b0;
    repeat (11) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
      do_op(ro, ra, rb, 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
